jacobi_result_reader: RTL and testbench

JACOBI_RESULT_READER -- requirements
Module: jacobi_result_reader

---
 rtl/jacobi_result_reader_pkg.sv | 17 +
 rtl/jacobi_result_reader_skid.sv | 50 +++++
 rtl/jacobi_result_reader.sv | 156 +++++++++++++++
 tb/tb_jacobi_result_reader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jacobi_result_reader_pkg.sv
// Shared sizing constants and the readout FSM encoding for the Jacobi
// eigen-solver result reader.
package common;

    localparam int JACOBI_N                 = 8;
    localparam int JACOBI_OUTPUT_WORD_WIDTH = 20;
    localparam int JACOBI_ADDR_WIDTH        = 7;
    localparam int JACOBI_V_OFFSET          = 36;
    localparam int JACOBI_MEM_SIZE          = JACOBI_V_OFFSET + JACOBI_N * JACOBI_N;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } reader_state_t;

endpackage

// File: rtl/jacobi_result_reader_skid.sv
// Two-entry output FIFO. Entries are registers, so the head word stays
// stable while the downstream side stalls.
module jacobi_skid_fifo #(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             pop,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             wr_ptr;
    logic             rd_ptr;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & ready;
    assign out_data  = rd_ptr ? entry1 : entry0;

    // The reader never pushes into a full FIFO, so no overflow guard is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) begin
                    entry1 <= push_data;
                end else begin
                    entry0 <= push_data;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/jacobi_result_reader.sv
// Streams the N eigenvalues (packed upper-triangle diagonal) followed by the
// N*N eigenvector matrix from result memory onto a valid/ready stream.
module jacobi_result_reader
    import common::*;
#(
    parameter int N          = JACOBI_N,
    parameter int WORD_WIDTH = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int ADDR_WIDTH = JACOBI_ADDR_WIDTH,
    parameter int V_OFFSET   = JACOBI_V_OFFSET
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [WORD_WIDTH-1:0] mem_rd_data,
    output logic [WORD_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tuser,
    output logic                  m_tlast
);

    localparam int TOTAL = N + N * N;
    localparam int CNT_W = $clog2(TOTAL);
    localparam int FW    = WORD_WIDTH + 2;

    reader_state_t          state;
    reader_state_t          state_nxt;
    logic [CNT_W-1:0]       rd_cnt;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [ADDR_WIDTH-1:0]  step_dec;
    logic                   issue;
    logic                   last_read;
    logic                   eigen_phase;
    logic                   rd_pending;
    logic                   pend_user;
    logic                   pend_last;
    logic [1:0]             fifo_count;
    logic                   fifo_pop;
    logic [FW-1:0]          fifo_out;
    logic                   fifo_user;
    logic                   fifo_last;
    logic [2:0]             outstanding;
    logic                   credit_ok;

    assign last_read   = (rd_cnt == CNT_W'(TOTAL - 1));
    assign eigen_phase = (rd_cnt < CNT_W'(N));

    // A word being popped this cycle frees its slot, which keeps full throughput.
    assign outstanding = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, fifo_pop};
    assign credit_ok   = (outstanding < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The first read goes out in the start cycle itself so the first word is
    // valid two cycles later.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    issue     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (last_read) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_pop && fifo_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Diagonal k sits at the previous diagonal plus (N - k + 1); step_dec
    // counts up so the stride shrinks without a multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt   <= '0;
            rd_addr  <= '0;
            step_dec <= '0;
        end else if (issue) begin
            if (last_read) begin
                rd_cnt   <= '0;
                rd_addr  <= '0;
                step_dec <= '0;
            end else begin
                rd_cnt <= rd_cnt + CNT_W'(1);
                if (rd_cnt == CNT_W'(N - 1)) begin
                    rd_addr  <= ADDR_WIDTH'(V_OFFSET);
                    step_dec <= '0;
                end else if (eigen_phase) begin
                    rd_addr  <= rd_addr + (ADDR_WIDTH'(N) - step_dec);
                    step_dec <= step_dec + ADDR_WIDTH'(1);
                end else begin
                    rd_addr <= rd_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            pend_user  <= 1'b0;
            pend_last  <= 1'b0;
        end else begin
            rd_pending <= issue;
            pend_user  <= issue & ~eigen_phase;
            pend_last  <= issue & last_read;
        end
    end

    jacobi_skid_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pending),
        .push_data ({pend_last, pend_user, mem_rd_data}),
        .ready     (m_tready),
        .out_data  (fifo_out),
        .out_valid (m_tvalid),
        .pop       (fifo_pop),
        .count     (fifo_count)
    );

    assign fifo_user   = fifo_out[WORD_WIDTH];
    assign fifo_last   = fifo_out[WORD_WIDTH+1];
    assign m_tdata     = fifo_out[WORD_WIDTH-1:0];
    assign m_tuser     = m_tvalid & fifo_user;
    assign m_tlast     = m_tvalid & fifo_last;
    assign busy        = (state != IDLE);
    assign done        = (state == DRAIN) && fifo_pop && fifo_last;
    assign mem_rd_en   = issue;
    assign mem_rd_addr = rd_addr;

endmodule

// File: tb/tb_jacobi_result_reader.sv
// Scoreboard bench for jacobi_result_reader: a formula-based model queues the
// expected stream at each accepted start and a negedge monitor checks it.
module tb_jacobi_result_reader;

    localparam int N        = 8;
    localparam int WW       = 20;
    localparam int AW       = 7;
    localparam int VOFF     = 36;
    localparam int TOTAL    = N + N * N;
    localparam int MEM_SIZE = VOFF + N * N;

    localparam int RDY_ALWAYS = 0;
    localparam int RDY_TOGGLE = 1;
    localparam int RDY_RANDOM = 2;
    localparam int RDY_LOW    = 3;

    typedef struct packed {
        logic          last;
        logic          user;
        logic [WW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [WW-1:0] mem_rd_data;
    logic [WW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tuser;
    logic          m_tlast;

    logic [WW-1:0] mem_arr [128];
    exp_t          exp_q [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ready_mode = RDY_LOW;
    bit tog = 1'b1;
    int words_seen = 0;
    int dones_seen = 0;
    int reads_seen = 0;
    int start_cyc = 0;
    int first_valid_cyc = -1;
    int done_cyc = 0;
    int words0 = 0;
    int dones0 = 0;
    int reads0 = 0;
    bit   stall_prev = 1'b0;
    exp_t held;

    jacobi_result_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tuser     (m_tuser),
        .m_tlast     (m_tlast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with one-cycle read latency; junk is returned when not reading.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem_arr[mem_rd_addr];
        end else begin
            mem_rd_data <= WW'($urandom);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                RDY_ALWAYS: m_tready = 1'b1;
                RDY_TOGGLE: begin
                    m_tready = tog;
                    tog = ~tog;
                end
                RDY_RANDOM: m_tready = 1'($urandom_range(0, 1));
                default:    m_tready = 1'b0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic fillMemory(input bit identity);
        for (int a = 0; a < 128; a++) begin
            mem_arr[a] = identity ? WW'(a) : WW'($urandom);
        end
    endtask

    // Expected stream straight from the addressing rules.
    task automatic pushExpected();
        exp_t e;
        int   addr;
        for (int k = 0; k < N; k++) begin
            addr   = k * N - (k * (k - 1)) / 2;
            e.data = mem_arr[addr];
            e.user = 1'b0;
            e.last = 1'b0;
            exp_q.push_back(e);
        end
        for (int m = 0; m < N * N; m++) begin
            addr   = VOFF + m;
            e.data = mem_arr[addr];
            e.user = 1'b1;
            e.last = (m == N * N - 1);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and checks stall stability.
    always @(negedge clk) begin
        exp_t e;
        bit   xfer;
        bit   exp_done;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (mem_rd_en) begin
                reads_seen++;
                checkOutput("addr_range", 32'(mem_rd_addr < AW'(MEM_SIZE)), 32'd1);
            end
            if (stall_prev) begin
                checkOutput("stall_valid", 32'(m_tvalid), 32'd1);
                checkOutput("stall_word", 32'({m_tlast, m_tuser, m_tdata}), 32'(held));
            end
            if (m_tvalid && first_valid_cyc < 0) begin
                first_valid_cyc = cyc;
            end
            xfer     = m_tvalid && m_tready;
            exp_done = 1'b0;
            if (xfer) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL extra_word: got %0h, expected no word (cycle %0d)", m_tdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("tdata", 32'(m_tdata), 32'(e.data));
                    checkOutput("tuser", 32'(m_tuser), 32'(e.user));
                    checkOutput("tlast", 32'(m_tlast), 32'(e.last));
                    exp_done = e.last;
                end
            end
            if (done || xfer) begin
                checkOutput("done", 32'(done), 32'(exp_done));
            end
            if (done) begin
                dones_seen++;
                done_cyc = cyc;
            end
            stall_prev = m_tvalid && !m_tready;
            held       = {m_tlast, m_tuser, m_tdata};
        end
    end

    // Pulses start for one cycle; with align clear the caller is already
    // sitting on the rising edge the start cycle should follow.
    task automatic applyStimulus(input int mode, input bit align);
        ready_mode = mode;
        tog = 1'b1;
        if (align) begin
            @(posedge clk);
        end
        #1;
        checkOutput("idle_before_start", 32'(busy), 32'd0);
        start           = 1'b1;
        start_cyc       = cyc;
        first_valid_cyc = -1;
        words0          = words_seen;
        dones0          = dones_seen;
        reads0          = reads_seen;
        pushExpected();
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic waitDone(input int d0);
        int guard = 0;
        while (dones_seen == d0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        checkOutput("done_within_bound", 32'(guard < 3000), 32'd1);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
        checkOutput("rst_tdata", 32'(m_tdata), 32'd0);
        checkOutput("rst_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("rst_tuser", 32'(m_tuser), 32'd0);
        checkOutput("rst_tlast", 32'(m_tlast), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        m_tready    = 1'b0;
        mem_rd_data = '0;
        fillMemory(1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs();
        rst_n = 1'b1;

        // Identity memory, always ready: exact cycle timing.
        $display("[TB] run 1: identity memory, ready held high");
        applyStimulus(RDY_ALWAYS, 1'b1);
        waitDone(dones0);
        checkOutput("first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'd2);
        checkOutput("done_latency", 32'(done_cyc - start_cyc), 32'd73);
        checkOutput("run1_words", 32'(words_seen - words0), 32'(TOTAL));
        #1;
        checkOutput("idle_after_done", 32'(busy), 32'd0);

        $display("[TB] run 2: random memory, ready toggling");
        fillMemory(1'b0);
        applyStimulus(RDY_TOGGLE, 1'b1);
        waitDone(dones0);
        checkOutput("run2_words", 32'(words_seen - words0), 32'(TOTAL));

        $display("[TB] run 3: ready low for 20 cycles");
        fillMemory(1'b1);
        ready_mode = RDY_LOW;
        applyStimulus(RDY_LOW, 1'b1);
        repeat (19) @(posedge clk);
        #1;
        checkOutput("stall_reads", 32'(reads_seen - reads0 <= 2), 32'd1);
        checkOutput("stall_tvalid", 32'(m_tvalid), 32'd1);
        checkOutput("stall_tdata", 32'(m_tdata), 32'd0);
        ready_mode = RDY_RANDOM;
        waitDone(dones0);
        checkOutput("run3_words", 32'(words_seen - words0), 32'(TOTAL));

        $display("[TB] run 4: second start while busy");
        fillMemory(1'b0);
        applyStimulus(RDY_RANDOM, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        checkOutput("busy_at_cycle10", 32'(busy), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(dones0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("run4_dones", 32'(dones_seen - dones0), 32'd1);
        checkOutput("run4_words", 32'(words_seen - words0), 32'(TOTAL));
        checkOutput("run4_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] run 5: reset at word 40");
        applyStimulus(RDY_RANDOM, 1'b1);
        for (int g = 0; g < 2000 && (words_seen - words0) < 40; g++) begin
            @(posedge clk);
        end
        checkOutput("reached_word40", 32'(words_seen - words0 >= 40), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs();
        exp_q.delete();
        rst_n = 1'b1;
        fillMemory(1'b1);
        applyStimulus(RDY_ALWAYS, 1'b1);
        waitDone(dones0);
        checkOutput("run5_words", 32'(words_seen - words0), 32'(TOTAL));
        checkOutput("run5_done_latency", 32'(done_cyc - start_cyc), 32'd73);

        $display("[TB] run 6: back-to-back readouts");
        fillMemory(1'b0);
        applyStimulus(RDY_RANDOM, 1'b1);
        waitDone(dones0);
        applyStimulus(RDY_RANDOM, 1'b0);
        waitDone(dones0);
        checkOutput("run6_second_words", 32'(words_seen - words0), 32'(TOTAL));

        for (int r = 0; r < 3; r++) begin
            fillMemory(1'b0);
            applyStimulus(RDY_RANDOM, 1'b1);
            waitDone(dones0);
            checkOutput("random_run_words", 32'(words_seen - words0), 32'(TOTAL));
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
